// File: rtl/adc_read_scheduler.sv
// rtl/adc_read_scheduler.sv - supervised XADC DRP read sequencer with running average
//
// Each SOC_TICK starts one transaction. The block waits for an end-of-conversion
// on channel ADDR[4:0], pulses DEN for one cycle, waits for DRDY, captures DO[15:4]
// and folds it into a 2^LOG2_AVG sample average. Each wait state is bounded by
// TIMEOUT_CYC cycles.
//
// Ports:
//   CLK, RST_N          clock (XADC dclk) and synchronous active-low reset
//   SOC_TICK            one-cycle start request
//   EOC, CHANNEL        XADC end-of-conversion strobe and its channel
//   DRDY, DO            XADC DRP read handshake and data
//   DEN, DADDR          DRP enable pulse and constant DRP address
//   SAMPLE/SAMPLE_VALID last captured 12-bit sample and its update strobe
//   AVG/AVG_VALID       last completed average and its update strobe
//   BUSY                high while a transaction is in progress
//   TIMEOUT, OVERRUN    wait-state expiry and dropped-start pulses
module adc_read_scheduler #(
    parameter logic [6:0] ADDR        = 7'h10,
    parameter int         LOG2_AVG    = 2,
    parameter int         TIMEOUT_CYC = 255
) (
    input  logic        CLK,
    input  logic        RST_N,
    input  logic        SOC_TICK,
    input  logic        EOC,
    input  logic [4:0]  CHANNEL,
    input  logic        DRDY,
    input  logic [15:0] DO,
    output logic        DEN,
    output logic [6:0]  DADDR,
    output logic [11:0] SAMPLE,
    output logic        SAMPLE_VALID,
    output logic [11:0] AVG,
    output logic        AVG_VALID,
    output logic        BUSY,
    output logic        TIMEOUT,
    output logic        OVERRUN
);

    // Counter keeps at least one bit so LOG2_AVG=0 still elaborates; with a
    // last-index of 0 every capture completes an average.
    localparam int              CW   = (LOG2_AVG > 0) ? LOG2_AVG : 1;
    localparam int              AW   = 12 + LOG2_AVG;
    localparam logic [CW-1:0]   LAST = CW'((1 << LOG2_AVG) - 1);
    localparam logic [15:0]     TMO  = 16'(TIMEOUT_CYC);

    typedef enum logic [1:0] {
        S_IDLE,
        S_WAIT_EOC,
        S_ISSUE,
        S_WAIT_DRDY
    } state_t;

    state_t          state;
    logic [15:0]     wait_cnt;
    logic [AW-1:0]   acc;
    logic [CW-1:0]   cnt;
    logic [11:0]     sample_q;
    logic [11:0]     avg_q;
    logic            den_q;
    logic            sample_valid_q;
    logic            avg_valid_q;
    logic            busy_q;
    logic            timeout_q;
    logic            overrun_q;

    logic [11:0]     sample_new;
    logic [AW-1:0]   sum;
    logic [AW-1:0]   sum_shr;
    logic            eoc_hit;
    logic            unused_do;

    assign sample_new = DO[15:4];
    assign unused_do  = ^DO[3:0];
    assign sum        = acc + AW'(sample_new);
    assign sum_shr    = sum >> LOG2_AVG;
    assign eoc_hit    = EOC && (CHANNEL == ADDR[4:0]);

    always_ff @(posedge CLK) begin
        if (!RST_N) begin
            state          <= S_IDLE;
            wait_cnt       <= '0;
            acc            <= '0;
            cnt            <= '0;
            sample_q       <= '0;
            avg_q          <= '0;
            den_q          <= 1'b0;
            sample_valid_q <= 1'b0;
            avg_valid_q    <= 1'b0;
            busy_q         <= 1'b0;
            timeout_q      <= 1'b0;
            overrun_q      <= 1'b0;
        end else begin
            den_q          <= 1'b0;
            sample_valid_q <= 1'b0;
            avg_valid_q    <= 1'b0;
            timeout_q      <= 1'b0;
            // A start while busy is dropped, never queued.
            overrun_q      <= SOC_TICK && busy_q;

            case (state)
                S_IDLE: begin
                    if (SOC_TICK) begin
                        state    <= S_WAIT_EOC;
                        wait_cnt <= '0;
                        busy_q   <= 1'b1;
                    end
                end
                S_WAIT_EOC: begin
                    // The awaited event is checked first so it wins over expiry.
                    if (eoc_hit) begin
                        state <= S_ISSUE;
                        den_q <= 1'b1;
                    end else if (wait_cnt == TMO) begin
                        state     <= S_IDLE;
                        busy_q    <= 1'b0;
                        timeout_q <= 1'b1;
                    end else begin
                        wait_cnt <= wait_cnt + 16'd1;
                    end
                end
                S_ISSUE: begin
                    state    <= S_WAIT_DRDY;
                    wait_cnt <= '0;
                end
                S_WAIT_DRDY: begin
                    if (DRDY) begin
                        state          <= S_IDLE;
                        busy_q         <= 1'b0;
                        sample_q       <= sample_new;
                        sample_valid_q <= 1'b1;
                        if (cnt == LAST) begin
                            avg_q       <= sum_shr[11:0];
                            avg_valid_q <= 1'b1;
                            acc         <= '0;
                            cnt         <= '0;
                        end else begin
                            acc <= sum;
                            cnt <= cnt + 1'b1;
                        end
                    end else if (wait_cnt == TMO) begin
                        state     <= S_IDLE;
                        busy_q    <= 1'b0;
                        timeout_q <= 1'b1;
                    end else begin
                        wait_cnt <= wait_cnt + 16'd1;
                    end
                end
                default: begin
                    state  <= S_IDLE;
                    busy_q <= 1'b0;
                end
            endcase
        end
    end

    assign DEN          = den_q;
    assign DADDR        = ADDR;
    assign SAMPLE       = sample_q;
    assign SAMPLE_VALID = sample_valid_q;
    assign AVG          = avg_q;
    assign AVG_VALID    = avg_valid_q;
    assign BUSY         = busy_q;
    assign TIMEOUT      = timeout_q;
    assign OVERRUN      = overrun_q;

endmodule

// File: doc/adc_read_scheduler.md
# adc_read_scheduler

Sequencer for the XADC DRP read path: on each start tick it waits for an end-of-conversion on the configured auxiliary channel, issues a single DRP read, captures the 12-bit result and builds a power-of-two running average. It sits between the tick generator, the `xadc` instance and the voltage consumers (comparator, FF array, LCD). It replaces the free-running EOC-to-DEN loopback with a timed, supervised transaction that reports errors.

## Interface
- `ADDR`, default 7'h10: DRP address read; `ADDR[4:0]` is also the channel to match on `CHANNEL`.
- `LOG2_AVG`, default 2: average depth N = 2^LOG2_AVG; legal range 0..4.
- `TIMEOUT_CYC`, default 255: maximum cycles allowed in each wait state; legal range 2..65535.

Ports:
- `CLK` in 1: single clock, the same clock as `dclk_in` of the XADC.
- `RST_N` in 1: synchronous, active-low reset.
- `SOC_TICK` in 1: one-cycle start request.
- `EOC` in 1: XADC `eoc_out`.
- `CHANNEL` in 5: XADC `channel_out`.
- `DRDY` in 1: XADC `drdy_out`.
- `DO` in 16: XADC DRP data out.
- `DEN` out 1: DRP enable, one-cycle pulse.
- `DADDR` out 7: DRP address, constant `ADDR`.
- `SAMPLE` out 12: last captured sample, `DO[15:4]`.
- `SAMPLE_VALID` out 1: one-cycle pulse when `SAMPLE` updates.
- `AVG` out 12: last completed average.
- `AVG_VALID` out 1: one-cycle pulse when `AVG` updates.
- `BUSY` out 1: high whenever the state is not IDLE.
- `TIMEOUT` out 1: one-cycle pulse when a wait state expires.
- `OVERRUN` out 1: one-cycle pulse when `SOC_TICK` arrives while busy.

## Operation
- States:
  - IDLE.
  - WAIT_EOC.
  - ISSUE, in which `DEN`=1 for exactly one cycle.
  - WAIT_DRDY.
- Transitions:
  - IDLE goes to WAIT_EOC on `SOC_TICK`.
  - WAIT_EOC goes to ISSUE when `EOC`=1 and `CHANNEL`==`ADDR[4:0]`. An EOC on any other channel is ignored.
  - ISSUE always goes to WAIT_DRDY.
  - WAIT_DRDY goes to IDLE when `DRDY`=1.
- `DRDY` is ignored in every state except WAIT_DRDY. `EOC` is ignored in every state except WAIT_EOC.
- Timeout:
  - A 16-bit wait counter clears on entry to WAIT_EOC and on entry to WAIT_DRDY.
  - The counter increments on each cycle spent in the wait state without the awaited event.
  - When the count equals `TIMEOUT_CYC`, the block pulses `TIMEOUT` and returns to IDLE.
  - The accumulator and the sample count are left unchanged.
- Overrun: `SOC_TICK` while `BUSY`=1 is dropped and pulses `OVERRUN`. It is not queued.
- Accumulation:
  - The accumulator is (12+LOG2_AVG) bits wide, so it cannot overflow. The sample counter is LOG2_AVG bits wide.
  - On capture, sum = acc + `DO[15:4]`.
  - If count == N-1: `AVG` <= sum >> LOG2_AVG (truncating), acc <= 0, count <= 0, and `AVG_VALID` pulses.
  - Otherwise: acc <= sum and count increments.
  - With LOG2_AVG=0, every sample is also an average.
- `DO[3:0]` is discarded.

## Timing
- Reset values:
  - State is IDLE.
  - `DEN`, `SAMPLE_VALID`, `AVG_VALID`, `TIMEOUT`, `OVERRUN` and `BUSY` are 0.
  - `SAMPLE`, `AVG`, the accumulator, the sample count and the wait counter are 0.
  - `DADDR` = `ADDR` at all times, including during reset.
- `SOC_TICK` high in cycle t (IDLE): `BUSY`=1 from t+1.
- Matching `EOC` in cycle e: `DEN`=1 in cycle e+1 only.
- `DRDY` in cycle d (WAIT_DRDY):
  - `SAMPLE`, `SAMPLE_VALID`, and (when the average completes) `AVG` and `AVG_VALID` are valid in cycle d+1.
  - `BUSY`=0 in cycle d+1.
- A new `SOC_TICK` in cycle d+1 is accepted, giving back-to-back transactions.
- Timeout: with no event, `TIMEOUT`=1 and `BUSY`=0 appear exactly `TIMEOUT_CYC`+1 cycles after entry to the wait state.
- Simultaneous events:
  - `SOC_TICK` in the same cycle as the `DRDY` that completes a transaction counts as an overrun, because `BUSY`=1 in that cycle.
  - Awaited event and timeout in the same cycle: the event wins and no `TIMEOUT` pulse is issued.
- `RST_N` low in any cycle forces the reset values on the next edge. A read in flight is abandoned and a later `DRDY` is ignored.

## Test plan
- Single read with LOG2_AVG=0:
  - Stimulus: `SOC_TICK`, then `EOC` with `CHANNEL`=5'h10, then `DRDY` 3 cycles after `DEN` with `DO`=16'hABC0.
  - Required: one `DEN` pulse; `SAMPLE`=`AVG`=12'hABC with both valid pulses in the cycle after `DRDY`.
- Average of 4 (default parameters):
  - Stimulus: samples 12'h100, 12'h200, 12'h300, 12'h400.
  - Required: `SAMPLE_VALID` ×4; a single `AVG_VALID` on the 4th sample with `AVG`=12'h280.
  - Follow-up: a 5th sample of 12'h010 sets `SAMPLE`=12'h010 and leaves `AVG` unchanged.
- Channel filter:
  - Stimulus: `EOC` with `CHANNEL`=5'h11, then 5'h10.
  - Required: `DEN` only after the 5'h10 EOC.
- Timeouts:
  - Stimulus: no `EOC` after `SOC_TICK`.
  - Required with `TIMEOUT_CYC`=255: `TIMEOUT` pulse 256 cycles after entering WAIT_EOC; no `DEN`; the accumulator is unchanged, so the next average covers only valid samples.
  - Stimulus: `DEN` issued but no `DRDY`.
  - Required: `TIMEOUT` from WAIT_DRDY.
- Overrun and back-to-back:
  - Stimulus: `SOC_TICK` during WAIT_DRDY.
  - Required: `OVERRUN` pulse and no extra `DEN`.
  - Stimulus: `SOC_TICK` in cycle d+1.
  - Required: accepted.
- Reset mid-operation:
  - Stimulus: `RST_N` low for 1 cycle in WAIT_DRDY after 2 accumulated samples, then `DRDY`.
  - Required: no `SAMPLE_VALID`; all outputs at reset values.
  - Follow-up: a fresh 4-sample sequence yields the correct average, with no carry-over from before the reset.
